execute_stage: RTL and testbench

- Parametrised successor to the single-register execute latch. Sits between the ALU/compare logic and the memory/writeback stage of the pipelined CPU.
- Captures data, instruction, register values and status flags with a valid/ready handshake.
- A 2-entry skid buffer lets stalls from the downstream stage propagate without dropping an instruction.
- Adds flush, a configurable absolute-op opcode range, and a sticky error flag.

---
 rtl/execute_stage.sv | 136 +++++++++++++
 tb/tb_execute_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute-to-memory pipeline register with a two-entry skid buffer, flush,
// absolute-op decode and a sticky error flag.
module execute_stage #(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned OPW       = 5,
  parameter int unsigned ABS_OP_LO = 13,
  parameter int unsigned ABS_OP_HI = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] data,
  input  logic [DWIDTH-1:0] instr,
  input  logic [DWIDTH-1:0] register,
  input  logic [DWIDTH-1:0] mux_register,
  input  logic              full_stack,
  input  logic              empty_stack,
  input  logic              above,
  input  logic              equal,
  input  logic              below,
  input  logic              error,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] stored_data,
  output logic [DWIDTH-1:0] stored_instr,
  output logic [DWIDTH-1:0] stored_register,
  output logic [DWIDTH-1:0] r_abs,
  output logic [4:0]        RFlags,
  output logic              reset_regs,
  output logic              err_sticky,
  input  logic              err_clear
);

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic [DWIDTH-1:0] instr;
    logic [DWIDTH-1:0] regv;
    logic [DWIDTH-1:0] rabs;
    logic [4:0]        flags;
    logic              abs;
  } entry_t;

  entry_t     in_e;
  entry_t     out_q, out_d;
  entry_t     skid_q, skid_d;
  logic       out_valid_q, out_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       rdy_q, rdy_d;
  logic       err_q, err_d;
  logic       acc;
  logic [OPW-1:0] opcode;
  logic [31:0]    opc_ext;
  logic           abs_flag;

  assign opcode   = instr[DWIDTH-1 -: OPW];
  assign opc_ext  = 32'(opcode);
  // An inverted range (LO > HI) naturally matches nothing.
  assign abs_flag = (opc_ext >= ABS_OP_LO) && (opc_ext <= ABS_OP_HI);

  always_comb begin
    in_e.data  = data;
    in_e.instr = instr;
    in_e.regv  = register;
    in_e.rabs  = abs_flag ? mux_register : '0;
    in_e.flags = {error | empty_stack, below, equal, above, full_stack};
    in_e.abs   = abs_flag;
  end

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    err_d        = err_q;
    // rdy_q is ~skid_valid_q, so acceptance and a full skid never coincide.
    acc          = in_valid & rdy_q & ~flush;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (acc) begin
        out_d       = in_e;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (acc) begin
      skid_d       = in_e;
      skid_valid_d = 1'b1;
    end

    if (acc && in_e.flags[4]) begin
      err_d = 1'b1;
    end else if (err_clear) begin
      err_d = 1'b0;
    end

    rdy_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      rdy_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      rdy_q        <= rdy_d;
      err_q        <= err_d;
    end
  end

  assign in_ready        = rdy_q;
  assign out_valid       = out_valid_q;
  assign stored_data     = out_q.data;
  assign stored_instr    = out_q.instr;
  assign stored_register = out_q.regv;
  assign r_abs           = out_q.rabs;
  assign RFlags          = out_q.flags;
  assign reset_regs      = out_valid_q & out_q.abs;
  assign err_sticky      = err_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: driver pushes expected entries on
// acceptance, a negedge monitor pops and compares on each output transfer.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] data, instr, register, mux_register;
  logic        full_stack, empty_stack, above, equal, below, error;
  logic [31:0] stored_data, stored_instr, stored_register, r_abs;
  logic [4:0]  RFlags;
  logic        reset_regs, err_sticky, err_clear;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] d, i, r, ra;
    logic [4:0]  f;
    logic        a;
  } ent_t;

  ent_t q[$];
  bit   sticky = 1'b0;

  execute_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .instr(instr), .register(register), .mux_register(mux_register),
    .full_stack(full_stack), .empty_stack(empty_stack), .above(above), .equal(equal),
    .below(below), .error(error), .out_valid(out_valid), .out_ready(out_ready),
    .stored_data(stored_data), .stored_instr(stored_instr),
    .stored_register(stored_register), .r_abs(r_abs), .RFlags(RFlags),
    .reset_regs(reset_regs), .err_sticky(err_sticky), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference entry straight from the input rules.
  function automatic ent_t mk();
    ent_t e;
    int unsigned op;
    op   = instr >> 27;
    e.d  = data;
    e.i  = instr;
    e.r  = register;
    e.a  = (op >= 13) && (op <= 17);
    e.ra = e.a ? mux_register : 32'h0;
    e.f  = {error | empty_stack, below, equal, above, full_stack};
    return e;
  endfunction

  task automatic step();
    ent_t e;
    bit   acc, rs;
    e   = mk();
    rs  = rst;
    acc = in_valid && in_ready && !flush && rst;
    @(posedge clk);
    if (!rs) begin
      q.delete();
      sticky = 1'b0;
    end else begin
      if (flush) q.delete();
      if (acc) q.push_back(e);
      if (acc && e.f[4]) sticky = 1'b1;
      else if (err_clear) sticky = 1'b0;
    end
    #1;
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, rs ? (q.size() < 2) : 0);
    chk("err_sticky", err_sticky, sticky);
    if (!out_valid) chk("reset_regs_idle", reset_regs, 0);
  endtask

  task automatic set_entry(input logic [4:0] op, input logic [31:0] mr);
    data         = $urandom;
    instr        = {op, 27'($urandom)};
    register     = $urandom;
    mux_register = mr;
  endtask

  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        chk("stored_data", stored_data, q[0].d);
        chk("stored_instr", stored_instr, q[0].i);
        chk("stored_register", stored_register, q[0].r);
        chk("r_abs", r_abs, q[0].ra);
        chk("RFlags", 32'(RFlags), 32'(q[0].f));
        chk("reset_regs", reset_regs, q[0].a);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; flush = 0; in_valid = 0; out_ready = 0; err_clear = 0;
    data = 0; instr = 0; register = 0; mux_register = 0;
    full_stack = 0; empty_stack = 0; above = 0; equal = 0; below = 0; error = 0;
    #1;
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_stored_data", stored_data, 0);
    rst = 1;
    step();
    chk("release_in_ready", in_ready, 1);

    // Pass-through, abs opcode then non-abs opcode.
    out_ready = 1; in_valid = 1;
    set_entry(5'd14, 32'h0000_00AA);
    step();
    chk("pt_r_abs", r_abs, 32'hAA);
    chk("pt_reset_regs", reset_regs, 1);
    chk("pt_instr", stored_instr, instr);
    set_entry(5'd12, 32'h0000_00AA);
    step();
    chk("pt12_r_abs", r_abs, 0);
    chk("pt12_reset_regs", reset_regs, 0);
    in_valid = 0;
    step();

    // Backpressure: A, B accepted, C held upstream.
    out_ready = 0; in_valid = 1;
    set_entry(5'd15, 32'h1111_1111); step();
    set_entry(5'd3, 32'h2222_2222);  step();
    chk("bp_in_ready_after_b", in_ready, 0);
    set_entry(5'd16, 32'h3333_3333); step();
    chk("bp_c_held", in_ready, 0);
    out_ready = 1;
    step(); step();
    in_valid = 0;
    step(); step();
    chk("bp_drained", out_valid, 0);

    // Flag packing and sticky error set-wins-over-clear.
    in_valid = 1; set_entry(5'd1, 32'h0);
    full_stack = 1; equal = 1; empty_stack = 1;
    step();
    chk("flags_packed", 32'(RFlags), 32'h15);
    chk("flags_sticky", err_sticky, 1);
    full_stack = 0; equal = 0; empty_stack = 0; error = 1; err_clear = 1;
    set_entry(5'd2, 32'h0);
    step();
    chk("sticky_set_wins", err_sticky, 1);
    error = 0; err_clear = 0; in_valid = 0;
    step();

    // Flush while both entries are full.
    out_ready = 0; in_valid = 1;
    set_entry(5'd13, 32'hABCD); step();
    set_entry(5'd17, 32'hBCDE); step();
    flush = 1; set_entry(5'd14, 32'h5); step();
    flush = 0; in_valid = 0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_reset_regs", reset_regs, 0);
    chk("flush_sticky_kept", err_sticky, 1);

    // Reset mid-operation with both entries full.
    in_valid = 1;
    set_entry(5'd14, 32'h77); step();
    set_entry(5'd15, 32'h88); step();
    rst = 0; step();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_data", stored_data, 0);
    chk("mid_rst_instr", stored_instr, 0);
    chk("mid_rst_reg", stored_register, 0);
    chk("mid_rst_r_abs", r_abs, 0);
    chk("mid_rst_flags", 32'(RFlags), 0);
    chk("mid_rst_reset_regs", reset_regs, 0);
    chk("mid_rst_sticky", err_sticky, 0);
    rst = 1; in_valid = 0; step();
    chk("mid_rst_release_ready", in_ready, 1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      in_valid    = $urandom_range(0, 1);
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      err_clear   = ($urandom_range(0, 9) == 0);
      rst         = ($urandom_range(0, 49) != 0);
      set_entry(5'($urandom_range(10, 20)), $urandom);
      full_stack  = $urandom_range(0, 1);
      empty_stack = ($urandom_range(0, 7) == 0);
      above       = $urandom_range(0, 1);
      equal       = $urandom_range(0, 1);
      below       = $urandom_range(0, 1);
      error       = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
